// File: rtl/sync_filter.sv
// Multi-channel asynchronous-input synchronizer with per-channel glitch filter
// and registered rise/fall pulses on the filtered level.
module sync_filter #(
  parameter int   WIDTH      = 4,
  parameter int   STAGES     = 2,
  parameter int   FILTER_CNT = 3,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CNT_W = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CNT - 1);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [STAGES-1:0] sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              filt_q, filt_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sync_lvl;

    assign sync_lvl = sync_q[STAGES-1];

    // A new level is accepted only after FILTER_CNT consecutive differing cycles;
    // any agreement in between restarts the count.
    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync_lvl != filt_q) begin
        if (cnt_q == CNT_MAX) begin
          filt_d = sync_lvl;
          rise_d = sync_lvl;
          fall_d = ~sync_lvl;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        sync_q <= {STAGES{RST_VAL}};
        cnt_q  <= '0;
        filt_q <= RST_VAL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[STAGES-2:0], async_in[g]};
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign sync_out[g] = sync_lvl;
    assign filt_out[g] = filt_q;
    assign rise[g]     = rise_q;
    assign fall[g]     = fall_q;
  end

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: default instance plus a STAGES=3/FILTER_CNT=1 instance.
`timescale 1ns/1ps
module tb_sync_filter;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_rst;

  logic [3:0] async_in, sync_out, filt_out, rise, fall;
  logic [3:0] async_p, sync_p, filt_p, rise_p, fall_p;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_CNT(3), .RST_VAL(1'b0)) u_dut (
    .clk(clk), .n_rst(n_rst), .async_in(async_in),
    .sync_out(sync_out), .filt_out(filt_out), .rise(rise), .fall(fall)
  );

  sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_CNT(1), .RST_VAL(1'b0)) u_p (
    .clk(clk), .n_rst(n_rst), .async_in(async_p),
    .sync_out(sync_p), .filt_out(filt_p), .rise(rise_p), .fall(fall_p)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst    = 1'b0;
    async_in = 4'h0;
    async_p  = 4'h0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    n_rst    = 1'b1;
    async_in = 4'hF;
    async_p  = 4'h0;
    #2 n_rst = 1'b0;
    #1;
    n_cmp++; if (sync_out !== 4'h0) begin n_err++; $display("FAIL reset_sync: got %h want 0", sync_out); end
    n_cmp++; if (filt_out !== 4'h0) begin n_err++; $display("FAIL reset_filt: got %h want 0", filt_out); end
    n_cmp++; if (rise !== 4'h0) begin n_err++; $display("FAIL reset_rise: got %h want 0", rise); end
    n_cmp++; if (fall !== 4'h0) begin n_err++; $display("FAIL reset_fall: got %h want 0", fall); end
    n_cmp++; if (filt_p !== 4'h0) begin n_err++; $display("FAIL reset_filt_p: got %h want 0", filt_p); end
    tick();
    n_cmp++; if (sync_out !== 4'h0) begin n_err++; $display("FAIL reset_hold_sync: got %h want 0", sync_out); end
    async_in = 4'h0;
    tick();
    n_rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_clean_step();
    logic [3:0] exp;
    exp_q = {4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    async_in = 4'h1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++; if (rise !== exp) begin n_err++; $display("FAIL step_rise e%0d: got %h want %h", e, rise, exp); end
      n_cmp++; if (sync_out[0] !== (e >= 2)) begin n_err++; $display("FAIL step_sync e%0d: got %b want %b", e, sync_out[0], (e >= 2)); end
      n_cmp++; if (filt_out[0] !== (e >= 5)) begin n_err++; $display("FAIL step_filt e%0d: got %b want %b", e, filt_out[0], (e >= 5)); end
    end
  endtask

  task automatic test_glitch();
    async_in = 4'h3;
    for (int e = 1; e <= 7; e++) begin
      tick();
      n_cmp++; if (sync_out[1] !== (e == 2 || e == 3)) begin n_err++; $display("FAIL glitch_sync e%0d: got %b", e, sync_out[1]); end
      n_cmp++; if (filt_out[1] !== 1'b0) begin n_err++; $display("FAIL glitch_filt e%0d: got %b want 0", e, filt_out[1]); end
      n_cmp++; if (rise[1] !== 1'b0 || fall[1] !== 1'b0) begin n_err++; $display("FAIL glitch_pulse e%0d: rise %b fall %b want 0", e, rise[1], fall[1]); end
      if (e == 2) async_in = 4'h1;
    end
  endtask

  task automatic test_falling();
    async_in = 4'h5;
    for (int e = 1; e <= 6; e++) tick();
    n_cmp++; if (filt_out[2] !== 1'b1) begin n_err++; $display("FAIL fall_setup: got %b want 1", filt_out[2]); end
    async_in = 4'h1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      n_cmp++; if (fall[2] !== (e == 5)) begin n_err++; $display("FAIL fall_pulse e%0d: got %b want %b", e, fall[2], (e == 5)); end
      n_cmp++; if (rise[2] !== 1'b0) begin n_err++; $display("FAIL fall_rise e%0d: got %b want 0", e, rise[2]); end
      n_cmp++; if (filt_out[2] !== (e < 5)) begin n_err++; $display("FAIL fall_filt e%0d: got %b want %b", e, filt_out[2], (e < 5)); end
    end
  endtask

  task automatic test_multi_reset();
    logic [3:0] exp_r, exp_f;
    do_reset();
    n_cmp++; if (filt_out !== 4'h0) begin n_err++; $display("FAIL multi_setup: got %h want 0", filt_out); end
    async_in = 4'hA;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_r = (e == 5) ? 4'hA : 4'h0;
      exp_f = (e >= 5) ? 4'hA : 4'h0;
      n_cmp++; if (rise !== exp_r) begin n_err++; $display("FAIL multi_rise e%0d: got %h want %h", e, rise, exp_r); end
      n_cmp++; if (filt_out !== exp_f) begin n_err++; $display("FAIL multi_filt e%0d: got %h want %h", e, filt_out, exp_f); end
      n_cmp++; if (fall !== 4'h0) begin n_err++; $display("FAIL multi_fall e%0d: got %h want 0", e, fall); end
    end
    do_reset();
    async_in = 4'hA;
    for (int e = 1; e <= 3; e++) tick();
    n_rst = 1'b0;
    #1;
    n_cmp++; if (filt_out !== 4'h0 || sync_out !== 4'h0) begin n_err++; $display("FAIL midrst_clear: filt %h sync %h want 0", filt_out, sync_out); end
    n_cmp++; if (rise !== 4'h0 || fall !== 4'h0) begin n_err++; $display("FAIL midrst_pulse: rise %h fall %h want 0", rise, fall); end
    tick();
    n_rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_r = (e == 5) ? 4'hA : 4'h0;
      exp_f = (e >= 5) ? 4'hA : 4'h0;
      n_cmp++; if (rise !== exp_r) begin n_err++; $display("FAIL midrst_rise e%0d: got %h want %h", e, rise, exp_r); end
      n_cmp++; if (filt_out !== exp_f) begin n_err++; $display("FAIL midrst_filt e%0d: got %h want %h", e, filt_out, exp_f); end
    end
  endtask

  task automatic test_param_sweep();
    do_reset();
    async_p = 4'h1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_cmp++; if (filt_p[0] !== (e >= 4)) begin n_err++; $display("FAIL sweep_filt e%0d: got %b want %b", e, filt_p[0], (e >= 4)); end
      n_cmp++; if (rise_p[0] !== (e == 4)) begin n_err++; $display("FAIL sweep_rise e%0d: got %b want %b", e, rise_p[0], (e == 4)); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_falling();
    test_multi_reset();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 4: number of independent asynchronous input channels, legal range 1-32.
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per channel, legal range 2-4.
REQ-003 Parameter FILTER_CNT, default 3: consecutive stable cycles needed to accept a new level, legal range 1-16.
REQ-004 Parameter RST_VAL, default 1'b0: per-channel level loaded into all storage at reset.
REQ-005 Port clk  input  1: single system clock, all state updates on rising edge.
REQ-006 Port n_rst  input  1: asynchronous, active-low reset.
REQ-007 Port async_in  input  WIDTH: asynchronous levels, one bit per channel.
REQ-008 Port sync_out  output  WIDTH: final synchronizer stage per channel, unfiltered.
REQ-009 Port filt_out  output  WIDTH: glitch-filtered level per channel.
REQ-010 Port rise  output  WIDTH: one-cycle pulse when filt_out goes 0 to 1.
REQ-011 Port fall  output  WIDTH: one-cycle pulse when filt_out goes 1 to 0.

Function
REQ-012 Each channel SHALL be processed independently; no cross-channel logic.
REQ-013 Each channel SHALL pass async_in through a chain of STAGES flops; sync_out is the last flop.
REQ-014 sync_out SHALL reflect a change of async_in sampled at edge k after edge k+STAGES-1.
REQ-015 Each channel SHALL own a counter of width max(1,$clog2(FILTER_CNT)).
REQ-016 If sync_out equals filt_out on an edge, the counter SHALL clear to 0 and filt_out SHALL hold.
REQ-017 If sync_out differs from filt_out and counter < FILTER_CNT-1, the counter SHALL increment by 1 and filt_out SHALL hold.
REQ-018 If sync_out differs from filt_out and counter == FILTER_CNT-1, filt_out SHALL load sync_out and the counter SHALL clear to 0.
REQ-019 With FILTER_CNT=1, filt_out SHALL follow sync_out with exactly one cycle delay.
REQ-020 Total latency, async_in sampled change to filt_out change: STAGES+FILTER_CNT rising edges.
REQ-021 A sync_out pulse shorter than FILTER_CNT cycles SHALL NOT change filt_out and SHALL NOT produce rise or fall.
REQ-022 rise[i] and fall[i] SHALL be registered, asserted for exactly the one cycle in which filt_out[i] holds its new value.
REQ-023 rise[i] and fall[i] SHALL never be asserted together.
REQ-024 Simultaneous transitions on several channels SHALL produce independent, correctly timed pulses on each channel.
REQ-025 The counter SHALL never exceed FILTER_CNT-1 and SHALL never wrap.

Reset
REQ-026 While n_rst=0, every synchronizer flop and filt_out SHALL equal RST_VAL on all channels, counters SHALL be 0, and rise and fall SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-count SHALL discard the partial count; no rise or fall pulse SHALL appear at or after reset release unless a new qualified change occurs.
REQ-028 After n_rst deasserts, the first state update SHALL occur on the next rising clk edge.

Verification (defaults WIDTH=4, STAGES=2, FILTER_CNT=3, RST_VAL=0)
REQ-029 Reset check: n_rst=0 with async_in=4'hF -> sync_out, filt_out, rise and fall all 0 immediately, without a clock edge.
REQ-030 Clean step: async_in[0] goes 0 to 1 before edge 1 and is held -> sync_out[0]=1 after edge 2, filt_out[0]=1 and rise[0]=1 after edge 5, rise[0]=0 after edge 6.
REQ-031 Glitch rejection: async_in[1]=1 for 2 cycles, then 0 -> sync_out[1] pulses for 2 cycles; filt_out[1], rise[1] and fall[1] stay 0.
REQ-032 Falling edge: with filt_out[2]=1, async_in[2] goes to 0 and is held -> fall[2] pulses for 1 cycle after edge 5; rise[2] stays 0.
REQ-033 Multi-channel and reset mid-count: async_in goes 4'h0 to 4'hA -> rise=4'hA for one cycle after edge 5; in a repeat run, n_rst is pulsed low after edge 3 -> no pulse, and filt_out=0.
REQ-034 Parameter sweep: STAGES=3 and FILTER_CNT=1 -> step-to-filt_out latency of exactly 4 edges.
